// File: rtl/uart_tx_queue_if.sv
// Handshake bundle between a word producer / UartTX and the uart_tx_queue.
// Producer side: wr_en, wr_data, flush in; full, empty, count, overflow out.
// UART side: tx_ready in; tx_send, tx_data out. master = driver side, slave = queue.
interface uart_tx_queue_if #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
);
  logic                         wr_en;
  logic [WIDTH-1:0]             wr_data;
  logic                         flush;
  logic                         full;
  logic                         empty;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;
  logic                         tx_ready;
  logic                         tx_send;
  logic [WIDTH-1:0]             tx_data;

  modport master (
    output wr_en, wr_data, flush, tx_ready,
    input  full, empty, count, overflow, tx_send, tx_data
  );

  modport slave (
    input  wr_en, wr_data, flush, tx_ready,
    output full, empty, count, overflow, tx_send, tx_data
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Purpose: FIFO-buffered feeder that hands words to UartTX as clean one-cycle send pulses.
// Latency: push into an empty queue with tx_ready steadily high -> tx_send two cycles later.
// Backpressure: pushes when full (and no pop that cycle) are dropped with a one-cycle overflow pulse.
// Ports: clock, reset (sync, active-high); bus (slave modport): producer write/flush/status
// and the UartTX send/ready/data side.
module uart_tx_queue #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  uart_tx_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SEND, BUSY} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             rdy_q;
  logic             q_full, q_empty;
  logic             pop, push;
  logic             overflow_q;
  logic             tx_send_q;
  logic [WIDTH-1:0] tx_data_q;

  assign q_full  = (count_q == CW'(DEPTH));
  assign q_empty = (count_q == '0);

  // UartTX raises ready for a single cycle in its stop state, so a launch needs
  // two consecutive high samples (tx_ready now, rdy_q from last cycle).
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty && bus.tx_ready && rdy_q && !bus.flush) begin
          state_nxt = SEND;
          pop       = 1'b1;
        end
      end
      SEND: state_nxt = BUSY;
      // Leave only on a fresh busy->idle edge of ready.
      BUSY: if (bus.tx_ready && !rdy_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A full queue still accepts a write when the head leaves in the same cycle.
  assign push = bus.wr_en && (!q_full || pop) && !bus.flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state      <= state_nxt;
      rdy_q      <= bus.tx_ready;
      tx_send_q  <= (state_nxt == SEND);
      overflow_q <= bus.wr_en && q_full && !pop && !bus.flush;
      if (pop) tx_data_q <= mem[rd_ptr];

      // Flush empties the queue only; an in-flight frame is left to finish.
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.full     = q_full;
  assign bus.empty    = q_empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_send  = tx_send_q;
  assign bus.tx_data  = tx_data_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_tx_queue_if #(.WIDTH(9), .DEPTH(8)) bus ();

  uart_tx_queue #(.WIDTH(9), .DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic [8:0] wd;
    logic       fl;
    logic       rdy;
    logic       snd;
    logic [8:0] dat;
    logic [3:0] cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
  } vec_t;

  int         n_vec = 0;
  int         n_bad = 0;
  logic       model_en = 1'b0;
  int         busy_cnt = 0;
  int         busy_len = 6;
  logic [8:0] sent_q[$];
  vec_t       vt[21];

  function automatic vec_t mk(logic rst, logic wr, logic [8:0] wd, logic fl, logic rdy,
                              logic snd, logic [8:0] dat, logic [3:0] cnt,
                              logic emp, logic ful, logic ovf);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wd = wd; v.fl = fl; v.rdy = rdy;
    v.snd = snd; v.dat = dat; v.cnt = cnt; v.emp = emp; v.ful = ful; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later. When the
  // UART model is enabled it drops ready in the send cycle (as UartTX does
  // combinationally) and raises it again after busy_len cycles.
  task automatic cycle(input logic w, input logic [8:0] d, input logic f, input logic r);
    bus.wr_en = w; bus.wr_data = d; bus.flush = f; reset = r;
    @(posedge clock); #1;
    if (model_en) begin
      if (bus.tx_send) begin
        sent_q.push_back(bus.tx_data);
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      bus.tx_ready = (busy_cnt == 0);
    end
  endtask

  initial begin
    logic [8:0] exp_drain[8];
    logic       seen;
    int         lat;

    bus.wr_en = 1'b0; bus.wr_data = '0; bus.flush = 1'b0; bus.tx_ready = 1'b1;

    //          rst wr wd      fl rdy | snd dat     cnt emp ful ovf
    vt[0]  = mk(1, 0, 9'h000, 0, 1,    0, 9'h000, 0,  1,  0,  0); // reset state
    vt[1]  = mk(0, 1, 9'h1A5, 0, 1,    0, 9'h000, 1,  0,  0,  0); // push 0x1A5
    vt[2]  = mk(0, 0, 9'h000, 0, 1,    1, 9'h1A5, 0,  1,  0,  0); // send 2 cycles after push
    vt[3]  = mk(0, 0, 9'h000, 0, 0,    0, 9'h1A5, 0,  1,  0,  0); // busy, pulse was 1 cycle
    vt[4]  = mk(0, 0, 9'h000, 0, 0,    0, 9'h1A5, 0,  1,  0,  0);
    vt[5]  = mk(0, 0, 9'h000, 0, 1,    0, 9'h1A5, 0,  1,  0,  0); // busy -> idle edge
    vt[6]  = mk(0, 0, 9'h000, 0, 0,    0, 9'h1A5, 0,  1,  0,  0);
    for (int k = 0; k < 8; k++)                                    // fill with ready low
      vt[7+k] = mk(0, 1, 9'h100 + 9'(k), 0, 0, 0, 9'h1A5, 4'(k+1), 0, (k == 7), 0);
    vt[15] = mk(0, 1, 9'h108, 0, 0,    0, 9'h1A5, 8,  0,  1,  1); // 9th push dropped
    vt[16] = mk(0, 0, 9'h000, 0, 0,    0, 9'h1A5, 8,  0,  1,  0); // overflow lasts 1 cycle
    vt[17] = mk(0, 0, 9'h000, 0, 1,    0, 9'h1A5, 8,  0,  1,  0); // lone ready pulse
    vt[18] = mk(0, 0, 9'h000, 0, 0,    0, 9'h1A5, 8,  0,  1,  0); // -> no send
    vt[19] = mk(0, 0, 9'h000, 0, 1,    0, 9'h1A5, 8,  0,  1,  0); // ready rises
    vt[20] = mk(0, 1, 9'h0FF, 0, 1,    1, 9'h100, 8,  0,  1,  0); // pop + push while full

    for (int i = 0; i < 21; i++) begin
      bus.tx_ready = vt[i].rdy;
      cycle(vt[i].wr, vt[i].wd, vt[i].fl, vt[i].rst);
      chk($sformatf("v%0d tx_send", i),  32'(bus.tx_send),  32'(vt[i].snd));
      chk($sformatf("v%0d tx_data", i),  32'(bus.tx_data),  32'(vt[i].dat));
      chk($sformatf("v%0d count", i),    32'(bus.count),    32'(vt[i].cnt));
      chk($sformatf("v%0d empty", i),    32'(bus.empty),    32'(vt[i].emp));
      chk($sformatf("v%0d full", i),     32'(bus.full),     32'(vt[i].ful));
      chk($sformatf("v%0d overflow", i), 32'(bus.overflow), 32'(vt[i].ovf));
    end

    // Drain the full queue through the UART model; 0x0FF must come out last.
    model_en = 1'b1;
    busy_cnt = busy_len;
    bus.tx_ready = 1'b0;
    sent_q.delete();
    for (int c = 0; c < 400 && sent_q.size() < 8; c++) cycle(0, 9'h000, 0, 0);
    for (int c = 0; c < 20; c++) cycle(0, 9'h000, 0, 0);
    for (int k = 0; k < 7; k++) exp_drain[k] = 9'h101 + 9'(k);
    exp_drain[7] = 9'h0FF;
    chk("drain sends", 32'(sent_q.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("drain word %0d", k), (k < sent_q.size()) ? 32'(sent_q[k]) : 32'hFFFF,
          32'(exp_drain[k]));
    chk("drain empty", 32'(bus.empty), 32'd1);

    // Three back-to-back pushes come out in order as exactly three sends.
    sent_q.delete();
    cycle(1, 9'h001, 0, 0);
    cycle(1, 9'h002, 0, 0);
    cycle(1, 9'h003, 0, 0);
    for (int c = 0; c < 200 && sent_q.size() < 3; c++) cycle(0, 9'h000, 0, 0);
    for (int c = 0; c < 30; c++) cycle(0, 9'h000, 0, 0);
    chk("burst sends", 32'(sent_q.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("burst word %0d", k), (k < sent_q.size()) ? 32'(sent_q[k]) : 32'hFFFF,
          32'(k + 1));

    // Flush during a long frame: queue clears, nothing further is sent.
    busy_len = 30;
    sent_q.delete();
    for (int k = 0; k < 6; k++) cycle(1, 9'h0A0 + 9'(k), 0, 0);
    cycle(0, 9'h000, 0, 0);
    chk("pre-flush count", 32'(bus.count), 32'd5);
    cycle(0, 9'h000, 1, 0);
    chk("flush count", 32'(bus.count), 32'd0);
    chk("flush empty", 32'(bus.empty), 32'd1);
    chk("flush overflow", 32'(bus.overflow), 32'd0);
    for (int c = 0; c < 60; c++) cycle(0, 9'h000, 0, 0);
    chk("sends after flush", 32'(sent_q.size()), 32'd1);

    // Reset while tx_send is high abandons the word.
    busy_len = 6;
    cycle(1, 9'h155, 0, 0);
    seen = 1'b0;
    lat  = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.tx_send) seen = 1'b1;
      else begin
        cycle(0, 9'h000, 0, 0);
        lat++;
      end
    end
    chk("reset-test send seen", 32'(seen), 32'd1);
    chk("reset-test send latency", 32'(lat + 1), 32'd2);
    chk("reset-test tx_data", 32'(bus.tx_data), 32'h155);
    cycle(0, 9'h000, 0, 1);
    chk("reset tx_send", 32'(bus.tx_send), 32'd0);
    chk("reset empty", 32'(bus.empty), 32'd1);
    chk("reset count", 32'(bus.count), 32'd0);
    chk("reset tx_data", 32'(bus.tx_data), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
